// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared constants and grant encoding for the framebuffer
//               arbiter and its scanout FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int PIX_W   = 12;
    localparam int FB_W    = 320;
    localparam int FB_H    = 240;
    localparam int FB_SIZE = FB_W * FB_H;

    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_FETCH = 2'd1,
        GNT_W0    = 2'd2,
        GNT_W1    = 2'd3
    } grant_t;

endpackage
`default_nettype wire

// File: rtl/vga_pix_fifo.sv
`default_nettype none
// ============================================================================
// Module      : vga_pix_fifo
// Description : Scanout prefetch FIFO with flush; head holds its last shown
//               value while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pix_fifo
    import vga_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = PIX_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic [WIDTH-1:0]   r_hold;
    logic               w_push;
    logic               w_pop;

    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign w_push = push && !flush;
    assign w_pop  = pop && !flush && !empty;
    // An empty FIFO keeps presenting whatever the consumer last saw.
    assign head   = empty ? r_hold : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_hold   <= '0;
        end else begin
            r_hold <= head;
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vga_fb_arbiter
// Description : Single-port framebuffer arbiter: scanout prefetch with
//               watermark urgency, round-robin for two pixel writers.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W     = 17,
    parameter int FB_SIZE    = vga_pkg::FB_SIZE,
    parameter int FIFO_DEPTH = 8,
    parameter int LOW_WM     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              pix_rd,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    output logic              underflow,
    input  logic              w0_valid,
    input  logic [ADDR_W-1:0] w0_addr,
    input  logic [PIX_W-1:0]  w0_data,
    output logic              w0_ready,
    input  logic              w1_valid,
    input  logic [ADDR_W-1:0] w1_addr,
    input  logic [PIX_W-1:0]  w1_data,
    output logic              w1_ready,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [PIX_W-1:0]  ram_wdata,
    input  logic [PIX_W-1:0]  ram_rdata
);

    localparam int                c_CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_CNT_W:0]  c_LOW_WM  = (c_CNT_W + 1)'(LOW_WM);
    localparam logic [c_CNT_W:0]  c_DEPTH   = (c_CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] c_FB_LAST = ADDR_W'(FB_SIZE - 1);

    logic [ADDR_W-1:0]  r_fetch_addr;
    logic               r_inflight;
    logic               r_rr_ptr;
    logic               r_underflow;
    logic [c_CNT_W-1:0] w_count;
    logic               w_empty;
    logic [c_CNT_W:0]   w_credit;
    logic               w_urgent;
    logic               w_permit;
    logic               w0_in_range;
    logic               w1_in_range;
    grant_t             w_grant;

    assign w_credit    = {1'b0, w_count} + {{c_CNT_W{1'b0}}, r_inflight};
    assign w_urgent    = (w_credit < c_LOW_WM);
    assign w_permit    = (w_credit < c_DEPTH);
    assign w0_in_range = (w0_addr <= c_FB_LAST);
    assign w1_in_range = (w1_addr <= c_FB_LAST);
    assign pix_valid   = !w_empty;
    assign underflow   = r_underflow;

    // Fetches are suppressed on frame_start so the restarted stream begins cleanly at 0.
    always_comb begin
        w_grant = GNT_NONE;
        if (!rst) begin
            if (!frame_start && w_urgent) begin
                w_grant = GNT_FETCH;
            end else if (w0_valid && w1_valid) begin
                w_grant = r_rr_ptr ? GNT_W1 : GNT_W0;
            end else if (w0_valid) begin
                w_grant = GNT_W0;
            end else if (w1_valid) begin
                w_grant = GNT_W1;
            end else if (!frame_start && w_permit) begin
                w_grant = GNT_FETCH;
            end
        end
    end

    // Out-of-range writes are acknowledged but never reach the RAM.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        w0_ready  = 1'b0;
        w1_ready  = 1'b0;
        case (w_grant)
            GNT_FETCH: begin
                ram_en   = 1'b1;
                ram_addr = r_fetch_addr;
            end
            GNT_W0: begin
                w0_ready  = 1'b1;
                ram_en    = w0_in_range;
                ram_we    = w0_in_range;
                ram_addr  = w0_addr;
                ram_wdata = w0_data;
            end
            GNT_W1: begin
                w1_ready  = 1'b1;
                ram_en    = w1_in_range;
                ram_we    = w1_in_range;
                ram_addr  = w1_addr;
                ram_wdata = w1_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_addr <= '0;
            r_inflight   <= 1'b0;
            r_rr_ptr     <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_inflight <= (w_grant == GNT_FETCH);
            if (frame_start) begin
                r_fetch_addr <= '0;
            end else if (w_grant == GNT_FETCH) begin
                r_fetch_addr <= (r_fetch_addr == c_FB_LAST) ? '0 : r_fetch_addr + 1'b1;
            end
            if (w_grant == GNT_W0) begin
                r_rr_ptr <= 1'b1;
            end else if (w_grant == GNT_W1) begin
                r_rr_ptr <= 1'b0;
            end
            if (pix_rd && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    vga_pix_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIX_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (frame_start),
        .push      (r_inflight),
        .push_data (ram_rdata),
        .pop       (pix_rd),
        .head      (pix_data),
        .count     (w_count),
        .empty     (w_empty)
    );

endmodule
`default_nettype wire
